// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants for the MMIO serial controller: bus addresses, status bit
// positions and the TX/RX engine state encodings.
package uart_mmio_ctrl_pkg;

  localparam logic [31:0] SerialDate = 32'hBFD0_03F8;
  localparam logic [31:0] SerialStat = 32'hBFD0_03FC;

  localparam int ST_TXRDY = 0;
  localparam int ST_RXAV  = 1;
  localparam int ST_OVR   = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_fifo.sv
// Small synchronous FIFO with a combinational head. A push into a full FIFO
// is still taken when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB separates full (MSBs differ) from empty (all equal).
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO serial controller: data/status ports on the MEM-stage bus, TX/RX FIFOs
// and 8N1 transmit/receive engines sharing a single bit-period divider value.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic [31:0] ram_addr_i,
  input  logic [31:0] ram_data_i,
  input  logic        ram_we_i_n,
  input  logic [3:0]  ram_sel_i,
  input  logic        ram_ce_i,
  output logic [31:0] ram_data_o,
  output logic        txd,
  input  logic        rxd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  logic w_sel_dat, w_sel_sta, w_rd_dat, w_wr_dat, w_rd_sta;
  logic w_unused;

  assign w_sel_dat = ram_ce_i & (ram_addr_i == SerialDate);
  assign w_sel_sta = ram_ce_i & (ram_addr_i == SerialStat);
  assign w_rd_dat  = w_sel_dat & ram_we_i_n;
  assign w_wr_dat  = w_sel_dat & ~ram_we_i_n;
  assign w_rd_sta  = w_sel_sta & ram_we_i_n;
  assign w_unused  = ^{ram_sel_i, ram_data_i[31:8]};

  // ---------------- FIFOs ----------------
  logic [7:0] w_txf_head, w_rxf_head;
  logic       w_txf_empty, w_txf_full, w_rxf_empty, w_rxf_full;
  logic       w_tx_pop, w_rx_push, w_rx_pop;
  logic [7:0] r_rx_shift;

  assign w_rx_pop = w_rd_dat & ~w_rxf_empty;

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk_50M), .rst(rst), .i_push(w_wr_dat), .i_pop(w_tx_pop),
    .i_din(ram_data_i[7:0]), .o_head(w_txf_head), .o_empty(w_txf_empty), .o_full(w_txf_full)
  );

  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk_50M), .rst(rst), .i_push(w_rx_push), .i_pop(w_rx_pop),
    .i_din(r_rx_shift), .o_head(w_rxf_head), .o_empty(w_rxf_empty), .o_full(w_rxf_full)
  );

  // ---------------- bus read path / overrun ----------------
  logic       r_ovr;
  logic [2:0] w_status;

  always_comb begin
    w_status           = 3'b000;
    w_status[ST_TXRDY] = ~w_txf_full;
    w_status[ST_RXAV]  = ~w_rxf_empty;
    w_status[ST_OVR]   = r_ovr;
  end

  always_comb begin
    ram_data_o = 32'h0;
    if (w_rd_dat && !w_rxf_empty) ram_data_o = {24'h0, w_rxf_head};
    else if (w_rd_sta)            ram_data_o = {29'h0, w_status};
  end

  // A dropped byte sets the flag even if a status read clears it this cycle.
  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst)                                    r_ovr <= 1'b0;
    else if (w_rx_push & w_rxf_full & ~w_rx_pop) r_ovr <= 1'b1;
    else if (w_rd_sta)                          r_ovr <= 1'b0;
  end

  // ---------------- TX engine ----------------
  tx_state_e     r_tx_state, w_tx_next;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          w_tx_tick;
  logic          w_txd;

  assign w_tx_tick = (r_tx_cnt == DIV_LAST);
  assign txd       = w_txd;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) r_tx_state <= TX_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE:  if (!w_txf_empty)                    w_tx_next = TX_START;
      TX_START: if (w_tx_tick)                       w_tx_next = TX_DATA;
      TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7)   w_tx_next = TX_STOP;
      TX_STOP:  if (w_tx_tick)                       w_tx_next = TX_IDLE;
      default:                                       w_tx_next = TX_IDLE;
    endcase
  end

  // txd decodes straight from state, so an async reset forces the line high at once.
  always_comb begin
    w_txd    = 1'b1;
    w_tx_pop = 1'b0;
    case (r_tx_state)
      TX_IDLE:  w_tx_pop = ~w_txf_empty;
      TX_START: w_txd    = 1'b0;
      TX_DATA:  w_txd    = r_tx_shift[0];
      default:  w_txd    = 1'b1;
    endcase
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (w_tx_pop) begin
      r_tx_shift <= w_txf_head;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_tx_tick) begin
        r_tx_cnt <= '0;
        if (r_tx_state == TX_DATA) begin
          r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          r_tx_bit   <= r_tx_bit + 1'b1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- RX engine ----------------
  rx_state_e     r_rx_state, w_rx_next;
  logic [1:0]    r_rx_sync;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic          w_rxs, w_rx_tick, w_rx_half;

  assign w_rxs     = r_rx_sync[1];
  assign w_rx_tick = (r_rx_cnt == DIV_LAST);
  assign w_rx_half = (r_rx_cnt == HALF_LAST);

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) r_rx_sync <= 2'b11;
    else     r_rx_sync <= {r_rx_sync[0], rxd};
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (!w_rxs)                          w_rx_next = RX_START;
      RX_START: if (w_rx_half)                       w_rx_next = w_rxs ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7)   w_rx_next = RX_STOP;
      RX_STOP:  if (w_rx_tick)                       w_rx_next = RX_IDLE;
      default:                                       w_rx_next = RX_IDLE;
    endcase
  end

  // A low stop bit is a framing error: the byte is dropped without a flag.
  always_comb begin
    w_rx_push = 1'b0;
    if (r_rx_state == RX_STOP) w_rx_push = w_rx_tick & w_rxs;
  end

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
        end
        RX_START: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rxs, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed/randomized bench for uart_mmio_ctrl with a queue-based model of the
// FIFOs and status word, a serial line decoder on txd and an 8N1 driver on rxd.
module tb_uart_mmio_ctrl;
  import uart_mmio_ctrl_pkg::*;

  localparam int DIV = 16;

  logic        clk_50M = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ram_addr_i = 32'h0;
  logic [31:0] ram_data_i = 32'h0;
  logic        ram_we_i_n = 1'b1;
  logic [3:0]  ram_sel_i = 4'hF;
  logic        ram_ce_i = 1'b0;
  logic [31:0] ram_data_o;
  logic        txd;
  logic        rxd = 1'b1;

  uart_mmio_ctrl #(.CLK_FREQ(160), .BAUD(10), .FIFO_DEPTH(4)) dut (
    .clk_50M(clk_50M), .rst(rst), .ram_addr_i(ram_addr_i), .ram_data_i(ram_data_i),
    .ram_we_i_n(ram_we_i_n), .ram_sel_i(ram_sel_i), .ram_ce_i(ram_ce_i),
    .ram_data_o(ram_data_o), .txd(txd), .rxd(rxd)
  );

  always #5 clk_50M = ~clk_50M;

  int         tests = 0;
  int         fails = 0;
  int         txd_falls = 0;
  logic [7:0] tx_got[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_q[$];
  logic       rx_ovr_m = 1'b0;
  logic       tx_nfull_m = 1'b1;

  always @(negedge txd) txd_falls++;

  // Line decoder: find the start bit, then sample each bit at its middle.
  always begin : mon
    logic [7:0] mb;
    logic       ms;
    @(negedge txd);
    repeat (DIV / 2) @(posedge clk_50M);
    mb = 8'h0;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(posedge clk_50M);
      #1 mb[i] = txd;
    end
    repeat (DIV) @(posedge clk_50M);
    #1 ms = txd;
    if (ms) tx_got.push_back(mb);
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  task automatic bus_store(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk_50M);
    ram_ce_i = 1'b1; ram_we_i_n = 1'b0; ram_addr_i = a;
    ram_data_i = {24'($urandom), d};
    @(posedge clk_50M); #1;
    ram_ce_i = 1'b0; ram_we_i_n = 1'b1; ram_addr_i = $urandom;
  endtask

  task automatic bus_load(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_50M);
    ram_ce_i = 1'b1; ram_we_i_n = 1'b1; ram_addr_i = a;
    #1 d = ram_data_o;
    @(posedge clk_50M); #1;
    ram_ce_i = 1'b0; ram_addr_i = $urandom;
  endtask

  function automatic logic [31:0] stat_m();
    return {29'h0, rx_ovr_m, (rx_q.size() != 0), tx_nfull_m};
  endfunction

  task automatic rd_stat(input string tag);
    logic [31:0] v;
    bus_load(SerialStat, v);
    chk(tag, v, stat_m());
    rx_ovr_m = 1'b0;
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] v;
    logic [31:0] e;
    bus_load(SerialDate, v);
    e = (rx_q.size() != 0) ? {24'h0, rx_q.pop_front()} : 32'h0;
    chk(tag, v, e);
  endtask

  // 8N1 frame on rxd; the model stores the byte only when the stop bit is 1.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      cyc(DIV);
    end
    rxd = 1'b1;
    if (stop) begin
      if (rx_q.size() < 4) rx_q.push_back(b);
      else                 rx_ovr_m = 1'b1;
    end
    cyc(4);
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_got.size() < n; i++) cyc(1);
  endtask

  initial begin : main
    logic [7:0] b;
    logic [9:0] fr;
    int         cnt_m;
    int         falls0;

    #2 rst = 1'b1;
    cyc(3);
    @(negedge clk_50M) rst = 1'b0;
    cyc(2);

    chk("reset_txd", txd, 1);
    chk("reset_idle_rdata", ram_data_o, 0);
    rd_stat("reset_status");
    rd_data("empty_data_read");
    @(negedge clk_50M);
    ram_addr_i = SerialStat; ram_we_i_n = 1'b1; ram_ce_i = 1'b0;
    #1 chk("no_strobe_rdata", ram_data_o, 0);
    bus_store(SerialStat, 8'h77);
    rd_stat("status_store_ignored");

    // Single byte 0xA5: latency and bit-by-bit line check.
    bus_store(SerialDate, 8'hA5);
    tx_exp.push_back(8'hA5);
    chk("tx_lat_n1", txd, 1);
    cyc(1);
    chk("tx_lat_n2", txd, 0);
    fr = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cyc(i == 0 ? DIV / 2 : DIV);
      chk($sformatf("tx_a5_bit%0d", i), txd, fr[i]);
    end
    cyc(DIV / 2);
    chk("tx_a5_idle", txd, 1);
    b = $urandom;
    bus_store(SerialDate, b);
    tx_exp.push_back(b);
    wait_tx(2, 600);
    chk("tx_single_count", tx_got.size(), 2);
    for (int i = 0; i < 2; i++) chk($sformatf("tx_single_byte%0d", i), tx_got[i], tx_exp[i]);
    tx_got.delete(); tx_exp.delete();

    // Burst into a busy engine: FIFO holds 4, the fifth store is dropped.
    b = $urandom;
    bus_store(SerialDate, b);
    tx_exp.push_back(b);
    cyc(5);
    cnt_m = 0;
    for (int k = 0; k < 5; k++) begin
      b = $urandom;
      bus_store(SerialDate, b);
      if (cnt_m < 4) begin
        tx_exp.push_back(b);
        cnt_m++;
      end
    end
    tx_nfull_m = (cnt_m < 4);
    rd_stat("tx_burst_status");
    wait_tx(tx_exp.size(), 1500);
    cyc(400);
    chk("tx_burst_count", tx_got.size(), tx_exp.size());
    for (int i = 0; i < 5; i++) chk($sformatf("tx_burst_byte%0d", i), tx_got[i], tx_exp[i]);
    tx_nfull_m = 1'b1;
    tx_got.delete(); tx_exp.delete();
    rd_stat("tx_drained_status");

    // Single receive; bit0 still shows TX space.
    cyc(1);
    send_rx(8'($urandom), 1'b1);
    rd_stat("rx_one_status");
    rd_data("rx_one_data");
    rd_stat("rx_one_status_after");

    // Five frames without reads: fifth overruns.
    for (int k = 0; k < 5; k++) begin
      send_rx(8'($urandom), 1'b1);
      cyc(2);
    end
    rd_stat("rx_ovr_status");
    rd_stat("rx_ovr_cleared");
    for (int k = 0; k < 4; k++) rd_data($sformatf("rx_ovr_data%0d", k));
    rd_data("rx_drained_data");
    rd_stat("rx_drained_status");

    // Short glitch and a framing error must not store anything.
    rxd = 1'b0;
    cyc(4);
    rxd = 1'b1;
    cyc(40);
    rd_stat("rx_glitch_status");
    send_rx(8'($urandom), 1'b0);
    cyc(20);
    rd_stat("rx_frame_err_status");
    send_rx(8'($urandom), 1'b1);
    rd_stat("rx_recover_status");
    rd_data("rx_recover_data");

    // Reset in the middle of a frame with a second byte queued.
    bus_store(SerialDate, 8'($urandom));
    bus_store(SerialDate, 8'($urandom));
    for (int i = 0; i < 10 && txd !== 1'b0; i++) cyc(1);
    chk("rst_pre_txd", txd, 0);
    cyc(5);
    #2 rst = 1'b1;
    #1 chk("rst_txd_async", txd, 1);
    falls0 = txd_falls;
    cyc(2);
    @(negedge clk_50M) rst = 1'b0;
    rx_q.delete(); rx_ovr_m = 1'b0; tx_nfull_m = 1'b1;
    rd_stat("rst_status");
    cyc(400);
    chk("rst_no_frames", txd_falls - falls0, 0);
    chk("rst_txd_idle", txd, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
